pong_match_ctrl: RTL and testbench
==================================

# pong_match_ctrl

Match sequencer for the Pong game. It generates the 1 Hz countdown enable for the match timer and reloads that timer at match start. It also tracks both players' scores and runs the IDLE / SERVE / PLAY / PAUSE / OVER state machine that gates ball motion. It sits between the debounced button/paddle-event logic and the timer, ball and display blocks.

## Interface
- `CLK_HZ`, 50_000_000, clock cycles per second tick.
- `WIN_SCORE`, 7, score that ends the match immediately (1..15).
- `SERVE_SEC`, 2, whole seconds spent in SERVE before the ball launches (1..15).

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_start`  in  1  single-cycle pulse from the debounce block.
- `btn_pause`  in  1  single-cycle pulse, toggles PLAY/PAUSE.
- `p1_point`, `p2_point`  in  1 each  single-cycle pulse from the ball block; the named player scored.
- `t_min`, `t_sec1`, `t_sec2`  in  4 each  BCD digits from the countdown timer.
- `timer_start`  out  1  one-cycle decrement enable to the timer.
- `timer_rst_n`  out  1  active-low timer reload; timer reloads to 2:00.
- `ball_run`  out  1  ball may move.
- `serve_dir`  out  1  0 = launch toward P1, 1 = launch toward P2.
- `score1`, `score2`  out  4 each  binary scores.
- `winner`  out  2  00 none, 01 P1, 10 P2, 11 draw.
- `state`  out  3  current FSM state, for the display.

## Operation
- Reset values:
  - state = IDLE; scores = 0; winner = 00; serve_dir = 0.
  - timer_rst_n = 1; timer_start = 0; ball_run = 0.
  - prescaler = 0.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in SERVE and PLAY; holds its value in PAUSE.
  - Clears to 0 in IDLE, in OVER, and on every entry to SERVE.
  - `tick` is a registered flag, high for one cycle when the count wraps.
- States and transitions:
  - **IDLE → SERVE** on btn_start. Clears scores and winner; drives timer_rst_n low for exactly one cycle.
  - **SERVE**: ball_run = 0. Counts SERVE_SEC ticks, then → PLAY. btn_pause is ignored.
  - **PLAY**: ball_run = 1; timer_start = tick.
    - btn_pause → PAUSE.
    - A point pulse increments the scorer's score. serve_dir is set toward the conceding player (p1_point → 1, p2_point → 0).
    - After a point: → OVER if the new score equals WIN_SCORE, else → SERVE.
  - **PAUSE**: ball_run = 0, timer_start = 0. btn_pause → PLAY. All other inputs are ignored.
  - **PLAY → OVER** when t_min, t_sec1 and t_sec2 all read 0. winner = higher score, 11 on a tie.
  - **OVER**: ball_run = 0; scores and winner are held. btn_start behaves exactly as IDLE → SERVE (new match).
- Boundary cases:
  - Point pulses outside PLAY are ignored.
  - p1_point and p2_point in the same cycle: neither scores, serve_dir is unchanged, → SERVE.
  - A point and time-up in the same cycle: the point is applied first. If it reaches WIN_SCORE, that player wins; otherwise → OVER with winner computed from the updated scores.
  - btn_start and btn_pause in the same cycle in PLAY: btn_pause applies; btn_start is ignored outside IDLE/OVER.
  - Scores never exceed WIN_SCORE.
- Reset asserted mid-match returns every register to its reset value asynchronously. The timer has its own reset and is not reloaded by this block in that case.

## Timing
- All outputs except timer_start are registered.
- `timer_start` = tick AND (state == PLAY), decoded from registers. Timer digits change on the following edge.
- Button or point pulse at edge N: state and scores update at edge N+1.
- timer_rst_n is low during the cycle after the IDLE/OVER → SERVE transition edge.
- Time-up is sampled every cycle in PLAY; OVER is reached one edge after the digits read 0:00.
- SERVE → PLAY occurs on the edge following the SERVE_SEC-th tick, i.e. SERVE_SEC × CLK_HZ cycles after SERVE entry.

## Structure
- Shared package `pong_pkg` holds:
  - state encoding: IDLE = 0, SERVE = 1, PLAY = 2, PAUSE = 3, OVER = 4;
  - winner codes;
  - the 2:00 timer reload constants.
- Sub-module `sec_tick_gen` (parameter CLK_HZ; inputs en, clr; output tick) is the prescaler.
- The FSM, score and serve logic stay in the top level.

## Test plan
All scenarios use CLK_HZ = 4, WIN_SCORE = 3, SERVE_SEC = 2, with a behavioural timer model.

- **Start:** reset, then btn_start. Expect state = SERVE; one timer_rst_n low cycle; PLAY exactly 8 cycles after SERVE entry; ball_run = 1.
- **Points:** in PLAY, p1_point ×3, with SERVE completing between points. Expect score1 = 1, 2, 3 and serve_dir = 1 each time. After the third point: OVER, winner = 01, ball_run = 0.
- **Pause:** pause in PLAY with the prescaler at 2, hold 20 cycles, then unpause. Expect no timer_start during pause and the next timer_start exactly 2 cycles after unpause.
- **Time-up tie:** score 1–1, run the timer down to 0:00. Expect OVER and winner = 11.
- **Simultaneous point:** p1_point and p2_point in the same cycle. Expect scores unchanged, state = SERVE, serve_dir unchanged. Separately, p2_point with time-up at 1–0 → OVER, winner = 11.
- **Mid-match reset and rematch:** reset asserted mid-PLAY gives all outputs at reset values immediately. Separately, btn_start in OVER clears the scores and pulses timer_rst_n.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared encodings for the Pong match sequencer: FSM states, winner codes
// and the match timer reload value.
package pong_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPause = 3'd3,
    StOver  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WinNone = 2'b00,
    WinP1   = 2'b01,
    WinP2   = 2'b10,
    WinDraw = 2'b11
  } winner_e;

  // Countdown timer reload value, 2:00 as BCD digits.
  localparam logic [3:0] TimerMinInit  = 4'd2;
  localparam logic [3:0] TimerSec1Init = 4'd0;
  localparam logic [3:0] TimerSec2Init = 4'd0;

  function automatic winner_e winner_of(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2) return WinP1;
    if (s2 > s1) return WinP2;
    return WinDraw;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: counts 0..CLK_HZ-1 while enabled, holds otherwise.
// tick is registered and is high for the whole cycle in which the count sits at its last value.
module sec_tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  // The wrap happens on the edge that ends the tick cycle, so a consumer
  // sampling tick acts on the same edge the second boundary is crossed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CntMax);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/pause/over FSM, scores, serve direction
// and the 1 Hz decrement enable for the match countdown timer.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned WIN_SCORE = 7,
  parameter int unsigned SERVE_SEC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic [3:0] t_min,
  input  logic [3:0] t_sec1,
  input  logic [3:0] t_sec2,
  output logic       timer_start,
  output logic       timer_rst_n,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
  localparam logic [3:0] ServeLast = 4'(SERVE_SEC - 1);

  state_e     state_q;
  winner_e    winner_q;
  logic [3:0] score1_q, score2_q, serve_cnt_q;
  logic       serve_dir_q, timer_rst_n_q, ball_run_q;

  logic       tick, tick_en, tick_clr;
  logic       p1_only, p2_only, point_any, time_up, win_hit;
  logic [3:0] score1_nxt, score2_nxt;

  // Simultaneous point pulses cancel each other.
  assign p1_only    = p1_point & ~p2_point;
  assign p2_only    = p2_point & ~p1_point;
  assign point_any  = p1_point | p2_point;
  assign time_up    = (t_min == 4'd0) && (t_sec1 == 4'd0) && (t_sec2 == 4'd0);
  assign score1_nxt = score1_q + {3'd0, p1_only};
  assign score2_nxt = score2_q + {3'd0, p2_only};
  assign win_hit    = (score1_nxt == WinScore) || (score2_nxt == WinScore);

  assign tick_en  = (state_q == StServe) || (state_q == StPlay);
  // Any point in PLAY leaves for SERVE or OVER, both of which restart the second.
  assign tick_clr = (state_q == StIdle) || (state_q == StOver) ||
                    ((state_q == StPlay) && point_any);

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .clr (tick_clr),
    .tick(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      score1_q      <= 4'd0;
      score2_q      <= 4'd0;
      winner_q      <= WinNone;
      serve_dir_q   <= 1'b0;
      serve_cnt_q   <= 4'd0;
      timer_rst_n_q <= 1'b1;
      ball_run_q    <= 1'b0;
    end else begin
      timer_rst_n_q <= 1'b1;
      case (state_q)
        StIdle, StOver: begin
          if (btn_start) begin
            state_q       <= StServe;
            score1_q      <= 4'd0;
            score2_q      <= 4'd0;
            winner_q      <= WinNone;
            serve_cnt_q   <= 4'd0;
            timer_rst_n_q <= 1'b0;
            ball_run_q    <= 1'b0;
          end
        end
        StServe: begin
          if (tick) begin
            if (serve_cnt_q == ServeLast) begin
              state_q    <= StPlay;
              ball_run_q <= 1'b1;
            end else begin
              serve_cnt_q <= serve_cnt_q + 4'd1;
            end
          end
        end
        StPlay: begin
          // Points and time-up end the rally and take precedence over pause.
          if (point_any || time_up) begin
            score1_q   <= score1_nxt;
            score2_q   <= score2_nxt;
            ball_run_q <= 1'b0;
            if (p1_only) begin
              serve_dir_q <= 1'b1;
            end else if (p2_only) begin
              serve_dir_q <= 1'b0;
            end
            if (win_hit || time_up) begin
              state_q  <= StOver;
              winner_q <= winner_of(score1_nxt, score2_nxt);
            end else begin
              state_q     <= StServe;
              serve_cnt_q <= 4'd0;
            end
          end else if (btn_pause) begin
            state_q    <= StPause;
            ball_run_q <= 1'b0;
          end
        end
        StPause: begin
          if (btn_pause) begin
            state_q    <= StPlay;
            ball_run_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          ball_run_q <= 1'b0;
        end
      endcase
    end
  end

  assign timer_start = tick & (state_q == StPlay);
  assign timer_rst_n = timer_rst_n_q;
  assign ball_run    = ball_run_q;
  assign serve_dir   = serve_dir_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with CLK_HZ=4, WIN_SCORE=3, SERVE_SEC=2
// and a behavioural BCD countdown timer.
module tb_pong_match_ctrl;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_pause = 1'b0, p1_point = 1'b0, p2_point = 1'b0;
  logic [3:0] t_min = TimerMinInit, t_sec1 = TimerSec1Init, t_sec2 = TimerSec2Init;
  logic       timer_start, timer_rst_n, ball_run, serve_dir;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] state;

  logic        preset_req = 1'b0;
  logic [11:0] preset_val = 12'h000;
  int          n_vec = 0;
  int          n_err = 0;
  int          n;
  int          ts_seen;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .CLK_HZ   (4),
    .WIN_SCORE(3),
    .SERVE_SEC(2)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .p1_point   (p1_point),
    .p2_point   (p2_point),
    .t_min      (t_min),
    .t_sec1     (t_sec1),
    .t_sec2     (t_sec2),
    .timer_start(timer_start),
    .timer_rst_n(timer_rst_n),
    .ball_run   (ball_run),
    .serve_dir  (serve_dir),
    .score1     (score1),
    .score2     (score2),
    .winner     (winner),
    .state      (state)
  );

  // Countdown timer model; preset lets the bench jump near 0:00.
  always @(posedge clk) begin
    if (preset_req) begin
      {t_min, t_sec1, t_sec2} <= preset_val;
    end else if (!timer_rst_n) begin
      t_min  <= TimerMinInit;
      t_sec1 <= TimerSec1Init;
      t_sec2 <= TimerSec2Init;
    end else if (timer_start) begin
      if (t_sec2 != 4'd0) begin
        t_sec2 <= t_sec2 - 4'd1;
      end else if (t_sec1 != 4'd0) begin
        t_sec1 <= t_sec1 - 4'd1;
        t_sec2 <= 4'd9;
      end else if (t_min != 4'd0) begin
        t_min  <= t_min - 4'd1;
        t_sec1 <= 4'd5;
        t_sec2 <= 4'd9;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycles until state reaches st; 200 means the bound expired.
  task automatic wait_state(input logic [2:0] st, output int cnt);
    cnt = 0;
    while (state !== st && cnt < 200) begin
      cyc();
      cnt++;
    end
  endtask

  task automatic preset(input logic [11:0] val);
    preset_val = val;
    preset_req = 1'b1;
    cyc();
    preset_req = 1'b0;
  endtask

  initial begin
    // Reset values
    cyc();
    cyc();
    check("rst_state", state, 3'd0);
    check("rst_score1", score1, 4'd0);
    check("rst_score2", score2, 4'd0);
    check("rst_winner", winner, 2'b00);
    check("rst_serve_dir", serve_dir, 1'b0);
    check("rst_timer_rst_n", timer_rst_n, 1'b1);
    check("rst_timer_start", timer_start, 1'b0);
    check("rst_ball_run", ball_run, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Start: SERVE, one reload cycle, PLAY 8 cycles after entry
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    check("start_state", state, 3'd1);
    check("start_reload_lo", timer_rst_n, 1'b0);
    cyc();
    check("start_reload_hi", timer_rst_n, 1'b1);
    wait_state(3'd2, n);
    check("start_serve_len", n + 1, 8);
    check("start_ball_run", ball_run, 1'b1);

    // Points: P1 scores three times
    for (int i = 1; i <= 3; i++) begin
      p1_point = 1'b1;
      cyc();
      p1_point = 1'b0;
      check("pt_score1", score1, i);
      check("pt_serve_dir", serve_dir, 1'b1);
      if (i < 3) begin
        check("pt_state_serve", state, 3'd1);
        check("pt_ball_stop", ball_run, 1'b0);
        wait_state(3'd2, n);
        check("pt_serve_len", n, 8);
      end
    end
    check("win_state", state, 3'd4);
    check("win_winner", winner, 2'b01);
    check("win_ball_run", ball_run, 1'b0);
    check("win_score2", score2, 4'd0);

    // Rematch from OVER, then pause with prescaler held at 2
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    check("rematch_state", state, 3'd1);
    check("rematch_score1", score1, 4'd0);
    check("rematch_winner", winner, 2'b00);
    check("rematch_reload", timer_rst_n, 1'b0);
    wait_state(3'd2, n);
    cyc();
    btn_pause = 1'b1;
    cyc();
    btn_pause = 1'b0;
    check("pause_state", state, 3'd3);
    check("pause_ball_run", ball_run, 1'b0);
    ts_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (timer_start) ts_seen++;
      cyc();
    end
    check("pause_no_ts", ts_seen, 0);
    check("pause_held", state, 3'd3);
    btn_pause = 1'b1;
    cyc();
    btn_pause = 1'b0;
    check("unpause_state", state, 3'd2);
    check("unpause_ts_c1", timer_start, 1'b0);
    cyc();
    check("unpause_ts_c2", timer_start, 1'b1);
    cyc();
    check("unpause_digits", {t_min, t_sec1, t_sec2}, 12'h159);

    // Time-up with a 1-1 tie
    p1_point = 1'b1;
    cyc();
    p1_point = 1'b0;
    wait_state(3'd2, n);
    p2_point = 1'b1;
    cyc();
    p2_point = 1'b0;
    check("tie_serve_dir", serve_dir, 1'b0);
    wait_state(3'd2, n);
    preset(12'h001);
    n = 0;
    while ({t_min, t_sec1, t_sec2} != 12'h000 && n < 50) begin
      cyc();
      n++;
    end
    check("tie_zero_play", state, 3'd2);
    cyc();
    check("tie_state", state, 3'd4);
    check("tie_winner", winner, 2'b11);
    check("tie_scores", {score1, score2}, 8'h11);

    // Simultaneous points, ignored inputs in SERVE, point with time-up
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    wait_state(3'd2, n);
    p1_point = 1'b1;
    cyc();
    p1_point = 1'b0;
    wait_state(3'd2, n);
    p1_point = 1'b1;
    p2_point = 1'b1;
    cyc();
    p1_point = 1'b0;
    p2_point = 1'b0;
    check("both_scores", {score1, score2}, 8'h10);
    check("both_state", state, 3'd1);
    check("both_serve_dir", serve_dir, 1'b1);
    p2_point = 1'b1;
    btn_pause = 1'b1;
    cyc();
    p2_point = 1'b0;
    btn_pause = 1'b0;
    check("serve_ignore_state", state, 3'd1);
    check("serve_ignore_score2", score2, 4'd0);
    wait_state(3'd2, n);
    preset(12'h000);
    p2_point = 1'b1;
    cyc();
    p2_point = 1'b0;
    check("pt_tup_state", state, 3'd4);
    check("pt_tup_scores", {score1, score2}, 8'h11);
    check("pt_tup_winner", winner, 2'b11);
    check("pt_tup_serve_dir", serve_dir, 1'b0);

    // Rematch clears, then reset mid-PLAY
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    check("rematch2_scores", {score1, score2}, 8'h00);
    check("rematch2_winner", winner, 2'b00);
    check("rematch2_reload", timer_rst_n, 1'b0);
    wait_state(3'd2, n);
    p1_point = 1'b1;
    cyc();
    p1_point = 1'b0;
    wait_state(3'd2, n);
    check("mid_pre_score1", score1, 4'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", state, 3'd0);
    check("mid_rst_score1", score1, 4'd0);
    check("mid_rst_serve_dir", serve_dir, 1'b0);
    check("mid_rst_ball_run", ball_run, 1'b0);
    check("mid_rst_timer_rst_n", timer_rst_n, 1'b1);
    check("mid_rst_timer_start", timer_start, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
